// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: opcodes, FSM states,
// default latencies and the result record passed from the arithmetic block.
package md_unit_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_NONE  = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   // ok=0 marks a result that must not be committed (divide by zero)
   typedef struct packed {
      logic        ok;
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational multiply/divide datapath: op, a, b -> {HI, LO} plus a commit flag.
module md_arith
   import md_unit_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output md_res_t     res
);

   logic [63:0] prod_s, prod_u;
   logic        sdiv, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, dvs, quot_m, rem_m, quot, rem;

   always_comb begin
      // Low 64 bits of a product of sign-extended operands equal the signed product
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'b0, a} * {32'b0, b};

      // Signed divide on magnitudes; 0x80000000 / -1 wraps to 0x80000000 naturally
      sdiv   = (op == MD_DIV);
      a_neg  = sdiv & a[31];
      b_neg  = sdiv & b[31];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      dvs    = (b == 32'd0) ? 32'd1 : b_mag;
      quot_m = a_mag / dvs;
      rem_m  = a_mag % dvs;
      quot   = (a_neg ^ b_neg) ? -quot_m : quot_m;
      rem    = a_neg ? -rem_m : rem_m;

      res = '0;
      case (op)
         MD_MULT:         res = {1'b1, prod_s};
         MD_MULTU:        res = {1'b1, prod_u};
         MD_DIV, MD_DIVU: res = {(b != 32'd0), rem, quot};
         default:         res = '0;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle MD controller: fixed-latency busy window, HI/LO ownership and
// the D-stage stall request for MD-class instructions.
module md_unit_ctrl
   import md_unit_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [2:0]  op_E,
   input  logic [31:0] a_E,
   input  logic [31:0] b_E,
   input  logic        md_use_D,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        stall_md
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   md_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   md_res_t     pend_q, pend_d, arith;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   md_arith u_arith (
      .op  (op_E),
      .a   (a_E),
      .b   (b_E),
      .res (arith)
   );

   assign busy     = (state_q != ST_IDLE);
   assign stall_md = md_use_D & (busy | start_E);
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start_E) begin
               case (op_E)
                  MD_MULT, MD_MULTU: begin
                     state_d = ST_MUL;
                     cnt_d   = CW'(MUL_LAT - 1);
                     pend_d  = arith;
                  end
                  MD_DIV, MD_DIVU: begin
                     state_d = ST_DIV;
                     cnt_d   = CW'(DIV_LAT - 1);
                     pend_d  = arith;
                  end
                  MD_MTHI: hi_d = a_E;
                  MD_MTLO: lo_d = a_E;
                  default: ;
               endcase
            end
         end
         default: begin
            // New starts are ignored here; only the countdown advances
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (pend_q.ok) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed HI/LO and busy-window lengths.
module tb_md_unit_ctrl;
   import md_unit_ctrl_pkg::*;

   logic        clk, reset, start_E, md_use_D;
   logic [2:0]  op_E;
   logic [31:0] a_E, b_E, hi_out, lo_out;
   logic        busy, stall_md;

   int n_pass = 0, n_total = 0;
   bit chk_on = 0;

   md_unit_ctrl dut (
      .clk(clk), .reset(reset), .start_E(start_E), .op_E(op_E),
      .a_E(a_E), .b_E(b_E), .md_use_D(md_use_D),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall_md(stall_md)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Model: {ok, hi, lo} computed with plain integer arithmetic
   function automatic logic [64:0] mdl(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      logic [64:0] out;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      out = '0;
      case (op)
         MD_MULT:  begin p = 64'(sa * sb); out = {1'b1, p}; end
         MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; out = {1'b1, p}; end
         MD_DIV:   if (b != 0) begin
                      q = sa / sb; r = sa % sb;
                      out = {1'b1, r[31:0], q[31:0]};
                   end
         MD_DIVU:  if (b != 0) out = {1'b1, a % b, a / b};
         default:  out = '0;
      endcase
      return out;
   endfunction

   int          left;
   logic [64:0] mpend;
   logic [31:0] mhi, mlo;

   always @(posedge clk) begin
      if (reset) begin
         left = 0; mpend = '0; mhi = 0; mlo = 0;
      end else if (left > 0) begin
         left--;
         if (left == 0 && mpend[64]) {mhi, mlo} = mpend[63:0];
      end else if (start_E) begin
         case (op_E)
            MD_MULT, MD_MULTU: begin left = 5;  mpend = mdl(op_E, a_E, b_E); end
            MD_DIV, MD_DIVU:   begin left = 10; mpend = mdl(op_E, a_E, b_E); end
            MD_MTHI: mhi = a_E;
            MD_MTLO: mlo = a_E;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_hi", hi_out, mhi);
         chk("model_lo", lo_out, mlo);
         chk("model_busy", {31'b0, busy}, {31'b0, left > 0});
         chk("model_stall", {31'b0, stall_md}, {31'b0, md_use_D && (left > 0 || start_E)});
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic st0);
      @(posedge clk); #2;
      start_E = 1; op_E = op; a_E = a; b_E = b;
      #1 st0 = stall_md;
      @(posedge clk); #2;
      start_E = 0; op_E = MD_NONE; a_E = 0; b_E = 0;
   endtask

   task automatic wait_idle(output int nb, output int ns);
      nb = 0; ns = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         nb++;
         if (stall_md) ns++;
         @(posedge clk); #2;
      end
   endtask

   initial begin
      logic st0;
      int nb, ns;
      reset = 1; start_E = 0; op_E = MD_NONE; a_E = 0; b_E = 0; md_use_D = 0;
      @(posedge clk); #2; chk_on = 1;
      @(posedge clk); #2; reset = 0;
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_busy", {31'b0, busy}, 0);

      // mult -3*7 with a D-stage MD instruction waiting the whole time
      md_use_D = 1;
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, st0);
      wait_idle(nb, ns);
      chk("mult_busy_cycles", nb, 5);
      chk("mult_stall_cycles", ns + int'(st0), 6);
      chk("mult_stall_after", {31'b0, stall_md}, 0);
      chk("mult_hi", hi_out, 32'hFFFF_FFFF);
      chk("mult_lo", lo_out, 32'hFFFF_FFEB);
      md_use_D = 0;

      issue(MD_DIVU, 32'd100, 32'd7, st0);
      wait_idle(nb, ns);
      chk("divu_busy_cycles", nb, 10);
      chk("divu_hi", hi_out, 32'd2);
      chk("divu_lo", lo_out, 32'd14);

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, st0);
      wait_idle(nb, ns);
      chk("div_neg_hi", hi_out, 32'hFFFF_FFFF);
      chk("div_neg_lo", lo_out, 32'hFFFF_FFFD);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st0);
      wait_idle(nb, ns);
      chk("multu_hi", hi_out, 32'hFFFF_FFFE);
      chk("multu_lo", lo_out, 32'h0000_0001);

      // Divide by zero keeps preloaded HI/LO but still runs the full window
      issue(MD_MTHI, 32'h11, 32'd0, st0);
      chk("mthi_pre_hi", hi_out, 32'h11);
      chk("mthi_pre_busy", {31'b0, busy}, 0);
      issue(MD_MTLO, 32'h22, 32'd0, st0);
      issue(MD_DIV, 32'd5, 32'd0, st0);
      wait_idle(nb, ns);
      chk("div0_busy_cycles", nb, 10);
      chk("div0_hi", hi_out, 32'h11);
      chk("div0_lo", lo_out, 32'h22);

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st0);
      wait_idle(nb, ns);
      chk("div_ovf_hi", hi_out, 32'h0);
      chk("div_ovf_lo", lo_out, 32'h8000_0000);

      issue(MD_MTHI, 32'hDEAD, 32'd0, st0);
      wait_idle(nb, ns);
      chk("mthi_busy_cycles", nb, 0);
      chk("mthi_hi", hi_out, 32'hDEAD);

      // Starts while busy must not disturb the mult in flight
      issue(MD_MULT, 32'd2, 32'd3, st0);
      start_E = 1; op_E = MD_MTLO; a_E = 32'h55;
      @(posedge clk); #2;
      op_E = MD_DIV; a_E = 32'd9; b_E = 32'd3;
      @(posedge clk); #2;
      start_E = 0; op_E = MD_NONE; a_E = 0; b_E = 0;
      wait_idle(nb, ns);
      chk("busy_ign_remaining", nb, 3);
      chk("busy_ign_hi", hi_out, 32'h0);
      chk("busy_ign_lo", lo_out, 32'd6);
      @(posedge clk); #2;
      chk("busy_ign_idle", {31'b0, busy}, 0);

      issue(MD_NONE, 32'h99, 32'd1, st0);
      chk("none_busy", {31'b0, busy}, 0);
      issue(3'd6, 32'h99, 32'd1, st0);
      chk("undef_busy", {31'b0, busy}, 0);
      chk("undef_lo", lo_out, 32'd6);

      // Reset in the third busy cycle of a divide
      issue(MD_MTHI, 32'h77, 32'd0, st0);
      issue(MD_DIVU, 32'd100, 32'd7, st0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1;
      @(posedge clk); #2;
      reset = 0;
      chk("rst_mid_busy", {31'b0, busy}, 0);
      chk("rst_mid_hi", hi_out, 0);
      chk("rst_mid_lo", lo_out, 0);
      repeat (12) @(posedge clk);
      #2;
      chk("rst_mid_stays_idle", {31'b0, busy}, 0);
      chk("rst_mid_lo_after", lo_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
